// File: rtl/ahb_master_req_ctrl.sv
// Master-side AHB request controller: decodes the target slave, requests its
// arbiter, stalls the master until granted and releases after the last beat.
module ahb_master_req_ctrl #(
  parameter int SLAVE_NUM = 4,
  parameter int ADDR_W    = 32,
  parameter int SEL_LSB   = 28,
  parameter int SEL_W     = 2
) (
  input  logic                 hclk,
  input  logic                 hreset_n,
  input  logic [1:0]           m_htrans,
  input  logic [ADDR_W-1:0]    m_haddr,
  input  logic [2:0]           m_hburst,
  output logic                 m_hready,
  output logic                 m_hresp,
  output logic [SLAVE_NUM-1:0] hreq,
  input  logic [SLAVE_NUM-1:0] hgrant,
  input  logic [SLAVE_NUM-1:0] hwait,
  output logic [SLAVE_NUM-1:0] m_owner
);

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_OWN  = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [SEL_W-1:0]     idx;
  logic [SEL_W-1:0]     tgt;
  logic [SEL_W-1:0]     tgt_nxt;
  logic [4:0]           len;
  logic [4:0]           len_nxt;
  logic [3:0]           count;
  logic                 beat_seen;
  logic                 dec_err;
  logic                 sel_grant;
  logic                 sel_wait;
  logic                 beat;
  logic                 last_beat;
  logic                 own_entry;
  logic [SLAVE_NUM-1:0] tgt_oh;
  logic [SLAVE_NUM-1:0] hreq_nxt;
  logic                 unused_addr;

  function automatic logic [SLAVE_NUM-1:0] to_onehot(input logic [SEL_W-1:0] i);
    logic [SLAVE_NUM-1:0] oh;
    oh = '0;
    for (int s = 0; s < SLAVE_NUM; s++)
      oh[s] = (int'(i) == s);
    return oh;
  endfunction

  // Length 0 encodes an unbounded INCR burst.
  function automatic logic [4:0] burst_len(input logic [2:0] b);
    case (b)
      HBURST_SINGLE:               return 5'd1;
      HBURST_INCR:                 return 5'd0;
      HBURST_WRAP4, HBURST_INCR4:  return 5'd4;
      HBURST_WRAP8, HBURST_INCR8:  return 5'd8;
      default:                     return 5'd16;
    endcase
  endfunction

  assign idx         = m_haddr[SEL_LSB +: SEL_W];
  assign unused_addr = ^m_haddr;
  assign dec_err     = (int'(idx) >= SLAVE_NUM);

  assign tgt_oh    = to_onehot(tgt);
  assign sel_grant = |(hgrant & tgt_oh);
  assign sel_wait  = |(hwait & tgt_oh);
  assign beat      = ((m_htrans == HTRANS_NONSEQ) || (m_htrans == HTRANS_SEQ)) && !sel_wait;
  assign last_beat = (len != 5'd0) && ({1'b0, count} == (len - 5'd1));

  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt;
    len_nxt   = len;
    case (state)
      ST_IDLE: begin
        if (m_htrans == HTRANS_NONSEQ) begin
          if (dec_err) begin
            state_nxt = ST_ERR1;
          end else begin
            state_nxt = ST_REQ;
            tgt_nxt   = idx;
            len_nxt   = burst_len(m_hburst);
          end
        end
      end
      ST_REQ: begin
        if (sel_grant)
          state_nxt = ST_OWN;
      end
      ST_OWN: begin
        if (!sel_wait) begin
          // An INCR burst ends on IDLE, or on a fresh NONSEQ once it has moved data.
          if (len == 5'd0) begin
            if ((m_htrans == HTRANS_IDLE) || ((m_htrans == HTRANS_NONSEQ) && beat_seen))
              state_nxt = ST_IDLE;
          end else if (beat && last_beat) begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_ERR1: state_nxt = ST_ERR2;
      ST_ERR2: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign own_entry = (state != ST_OWN) && (state_nxt == ST_OWN);
  assign hreq_nxt  = ((state_nxt == ST_REQ) || (state_nxt == ST_OWN)) ? to_onehot(tgt_nxt) : '0;

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state     <= ST_IDLE;
      tgt       <= '0;
      len       <= 5'd1;
      count     <= 4'd0;
      beat_seen <= 1'b0;
      hreq      <= '0;
    end else begin
      state <= state_nxt;
      tgt   <= tgt_nxt;
      len   <= len_nxt;
      hreq  <= hreq_nxt;
      if (own_entry) begin
        count     <= 4'd0;
        beat_seen <= 1'b0;
      end else if ((state == ST_OWN) && beat && (state_nxt == ST_OWN)) begin
        count     <= count + 4'd1;
        beat_seen <= 1'b1;
      end
    end
  end

  always_comb begin
    m_hready = 1'b1;
    case (state)
      ST_IDLE: m_hready = (m_htrans != HTRANS_NONSEQ);
      ST_REQ:  m_hready = 1'b0;
      ST_OWN:  m_hready = !sel_wait;
      ST_ERR1: m_hready = 1'b0;
      ST_ERR2: m_hready = 1'b1;
      default: m_hready = 1'b1;
    endcase
  end

  assign m_hresp = (state == ST_ERR1) || (state == ST_ERR2);
  assign m_owner = (state == ST_OWN) ? tgt_oh : '0;

endmodule

// File: tb/tb_ahb_master_req_ctrl.sv
// Bench for ahb_master_req_ctrl: directed scenarios plus random traffic,
// checked each cycle against a transaction-level reference model.
module tb_ahb_master_req_ctrl;
  localparam int SN = 4;
  localparam int AW = 32;
  localparam int SL = 28;
  localparam int SW = 3;

  logic          hclk = 1'b0;
  logic          hreset_n;
  logic [1:0]    m_htrans;
  logic [AW-1:0] m_haddr;
  logic [2:0]    m_hburst;
  logic          m_hready;
  logic          m_hresp;
  logic [SN-1:0] hreq;
  logic [SN-1:0] hgrant;
  logic [SN-1:0] hwait;
  logic [SN-1:0] m_owner;

  int errors = 0;
  int checks = 0;

  always #5 hclk = ~hclk;

  ahb_master_req_ctrl #(.SLAVE_NUM(SN), .ADDR_W(AW), .SEL_LSB(SL), .SEL_W(SW)) dut (
    .hclk(hclk), .hreset_n(hreset_n), .m_htrans(m_htrans), .m_haddr(m_haddr),
    .m_hburst(m_hburst), .m_hready(m_hready), .m_hresp(m_hresp), .hreq(hreq),
    .hgrant(hgrant), .hwait(hwait), .m_owner(m_owner)
  );

  // Reference model: a transaction is either absent, waiting for grant, or owning
  // the bus with a number of beats done; an error response is a 2-cycle countdown.
  bit            act;
  bit            gnt_seen;
  bit            incr;
  int            tgt;
  int            blen;
  int            done;
  int            err_left;
  logic [SN-1:0] e_hreq;
  logic [SN-1:0] arb_q;
  bit            rnd;
  bit            last_rdy;
  logic [SN-1:0] watch;
  int            watch_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int beats_of(input logic [2:0] b);
    case (b)
      3'd0:       return 1;
      3'd1:       return 0;
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default:    return 16;
    endcase
  endfunction

  task automatic mdl_reset();
    act = 0; gnt_seen = 0; incr = 0; tgt = 0; blen = 1; done = 0;
    err_left = 0; e_hreq = '0; arb_q = '0;
  endtask

  task automatic check_now(input string tag);
    logic          exp_rdy;
    logic          exp_resp;
    logic [SN-1:0] exp_own;
    exp_own  = '0;
    exp_resp = 1'b0;
    if (err_left == 2) begin
      exp_rdy = 1'b0; exp_resp = 1'b1;
    end else if (err_left == 1) begin
      exp_rdy = 1'b1; exp_resp = 1'b1;
    end else if (act && !gnt_seen) begin
      exp_rdy = 1'b0;
    end else if (act) begin
      exp_rdy = !hwait[tgt];
      exp_own = SN'(1) << tgt;
    end else begin
      exp_rdy = (m_htrans != 2'd2);
    end
    last_rdy = exp_rdy;
    chk({tag, ".hready"}, 32'(m_hready), 32'(exp_rdy));
    chk({tag, ".hresp"}, 32'(m_hresp), 32'(exp_resp));
    chk({tag, ".owner"}, 32'(m_owner), 32'(exp_own));
    chk({tag, ".hreq"}, 32'(hreq), 32'(e_hreq));
    chk({tag, ".onehot"}, 32'($onehot0(hreq)), 32'd1);
  endtask

  task automatic model_step();
    int idx;
    if (err_left > 0) begin
      err_left--;
    end else if (!act) begin
      if (m_htrans == 2'd2) begin
        idx = int'(m_haddr[SL +: SW]);
        if (idx >= SN) begin
          err_left = 2;
        end else begin
          act = 1; tgt = idx; gnt_seen = 0; done = 0;
          blen = beats_of(m_hburst); incr = (blen == 0);
        end
      end
    end else if (!gnt_seen) begin
      if (hgrant[tgt]) gnt_seen = 1;
    end else if (!hwait[tgt]) begin
      if (incr && ((m_htrans == 2'd0) || ((m_htrans == 2'd2) && (done > 0)))) begin
        act = 0;
      end else if (m_htrans[1]) begin
        done++;
        if (!incr && (done == blen)) act = 0;
      end
    end
    e_hreq = act ? (SN'(1) << tgt) : '0;
  endtask

  // One bus cycle: drive at the falling edge, check just after, advance the model at the rising edge.
  task automatic cycle(input string tag, input logic [1:0] tr, input logic [AW-1:0] ad,
                       input logic [2:0] bu, input logic [SN-1:0] wt);
    logic [SN-1:0] noise;
    m_htrans = tr; m_haddr = ad; m_hburst = bu; hwait = wt;
    noise  = rnd ? SN'($urandom) : '0;
    hgrant = arb_q | (noise & ~e_hreq);
    #1;
    check_now(tag);
    if (hreq == watch) watch_cnt++;
    @(posedge hclk);
    arb_q = (rnd && ($urandom_range(0, 3) == 0)) ? '0 : e_hreq;
    model_step();
    @(negedge hclk);
  endtask

  logic [1:0]    tr;
  logic [AW-1:0] ad;
  logic [2:0]    bu;
  logic [SN-1:0] wt;
  logic [1:0]    p_tr;
  logic [AW-1:0] p_ad;
  logic [2:0]    p_bu;
  int            r;

  initial begin
    m_htrans = 2'd0; m_haddr = '0; m_hburst = 3'd0; hwait = '0; hgrant = '0;
    rnd = 0; watch = '1; watch_cnt = 0; last_rdy = 1'b1;
    mdl_reset();
    hreset_n = 1'b0;
    repeat (2) @(negedge hclk);
    #1;
    check_now("reset");
    hreset_n = 1'b1;
    @(negedge hclk);

    // SINGLE to slave 2: request held exactly 3 cycles
    watch = 4'b0100; watch_cnt = 0;
    repeat (4) cycle("single", 2'd2, 32'h2000_0000, 3'd0, 4'b0000);
    cycle("single.end", 2'd0, 32'h0, 3'd0, 4'b0000);
    cycle("single.idle", 2'd0, 32'h0, 3'd0, 4'b0000);
    chk("single.hreq_cycles", 32'(watch_cnt), 32'd3);
    chk("single.released", 32'(hreq), 32'h0);

    // INCR4 to slave 1, beat 2 stalled 2 cycles
    repeat (4) cycle("incr4.first", 2'd2, 32'h1000_0000, 3'd3, 4'b0000);
    cycle("incr4.wait", 2'd3, 32'h1000_0004, 3'd3, 4'b0010);
    chk("incr4.stall_rdy", 32'(m_hready), 32'd0);
    cycle("incr4.wait", 2'd3, 32'h1000_0004, 3'd3, 4'b0010);
    repeat (2) cycle("incr4.beat", 2'd3, 32'h1000_0008, 3'd3, 4'b0000);
    chk("incr4.hreq_before_last", 32'(hreq), 32'h2);
    cycle("incr4.last", 2'd3, 32'h1000_000c, 3'd3, 4'b0000);
    chk("incr4.hreq_after_last", 32'(hreq), 32'h0);
    cycle("incr4.idle", 2'd0, 32'h0, 3'd0, 4'b0000);

    // INCR to slave 0: 5 SEQ beats with a BUSY, then IDLE
    repeat (4) cycle("incr.first", 2'd2, 32'h0000_0000, 3'd1, 4'b0000);
    repeat (2) cycle("incr.seq", 2'd3, 32'h0000_0010, 3'd1, 4'b0000);
    cycle("incr.busy", 2'd1, 32'h0000_0010, 3'd1, 4'b0000);
    chk("incr.busy_holds", 32'(hreq), 32'h1);
    repeat (3) cycle("incr.seq", 2'd3, 32'h0000_0020, 3'd1, 4'b0000);
    chk("incr.still_owned", 32'(hreq), 32'h1);
    cycle("incr.idle", 2'd0, 32'h0, 3'd1, 4'b0000);
    chk("incr.dropped", 32'(hreq), 32'h0);

    // Decode error: slave index 4 does not exist
    cycle("derr.nonseq", 2'd2, 32'h4000_0000, 3'd0, 4'b0000);
    chk("derr.err1_resp", 32'({m_hresp, m_hready}), 32'b10);
    cycle("derr.err1", 2'd0, 32'h0, 3'd0, 4'b0000);
    chk("derr.err2_resp", 32'({m_hresp, m_hready}), 32'b11);
    cycle("derr.err2", 2'd0, 32'h0, 3'd0, 4'b0000);
    cycle("derr.after", 2'd0, 32'h0, 3'd0, 4'b0000);

    // Back-to-back: WRAP8 to slave 3 then NONSEQ to slave 0
    repeat (4) cycle("wrap8.first", 2'd2, 32'h3000_0000, 3'd4, 4'b0000);
    repeat (7) cycle("wrap8.seq", 2'd3, 32'h3000_0004, 3'd4, 4'b0000);
    chk("b2b.gap", 32'(hreq), 32'h0);
    cycle("b2b.nonseq", 2'd2, 32'h0000_0100, 3'd0, 4'b0000);
    chk("b2b.next", 32'(hreq), 32'h1);
    repeat (3) cycle("b2b.single", 2'd2, 32'h0000_0100, 3'd0, 4'b0000);
    cycle("b2b.idle", 2'd0, 32'h0, 3'd0, 4'b0000);

    // Asynchronous reset in the middle of an INCR16 to slave 2
    repeat (4) cycle("rst.first", 2'd2, 32'h2000_0000, 3'd7, 4'b0000);
    cycle("rst.seq", 2'd3, 32'h2000_0004, 3'd7, 4'b0000);
    m_htrans = 2'd3; hwait = 4'b0000;
    #2 hreset_n = 1'b0;
    #1;
    chk("rst.async_hreq", 32'(hreq), 32'h0);
    chk("rst.async_owner", 32'(m_owner), 32'h0);
    chk("rst.async_rdy_resp", 32'({m_hready, m_hresp}), 32'b10);
    mdl_reset();
    @(negedge hclk);
    hreset_n = 1'b1;
    repeat (2) cycle("rst.after", 2'd0, 32'h0, 3'd0, 4'b0000);

    // Random traffic
    rnd = 1;
    p_tr = 2'd0; p_ad = '0; p_bu = 3'd0;
    for (int n = 0; n < 2000; n++) begin
      if ((p_tr == 2'd2) && !last_rdy) begin
        tr = p_tr; ad = p_ad; bu = p_bu;
      end else begin
        r  = $urandom_range(0, 99);
        tr = (r < 25) ? 2'd0 : (r < 35) ? 2'd1 : (r < 60) ? 2'd2 : 2'd3;
        ad = $urandom;
        ad[SL +: SW] = SW'($urandom_range(0, 5));
        bu = 3'($urandom);
      end
      for (int b = 0; b < SN; b++) wt[b] = ($urandom_range(0, 3) == 0);
      cycle("rand", tr, ad, bu, wt);
      p_tr = tr; p_ad = ad; p_bu = bu;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
